noc_rr_arbiter: RTL
===================

Name: noc_rr_arbiter

Overview:
- Parametrised N-port arbiter for the NoC router output stage.
- Generalises the fixed 5-port (N/E/W/S/L) arbiter:
  - configurable port count;
  - true round-robin pointer;
  - starvation guard: forced rotation after MAX_HOLD consecutive grants to one port.
- Keeps the RTS/DCTS flow-control handshake toward the downstream router.
- Drives grants back to the input FIFOs and the one-hot crossbar select.

Parameters:
- NUM_PORTS, 5, number of requesting input ports (2..16); port 0 = Local.
- MAX_HOLD, 8, max consecutive grants to one owner while another port requests (1..255).
- CNT_W, $clog2(MAX_HOLD+1), width of hold counter (derived, not overridden).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req  in  NUM_PORTS  per-port request, level, from input FIFO empty flags.
- dcts  in  1  downstream clear-to-send (acknowledge of rts).
- grant  out  NUM_PORTS  one-hot; grant[i] = (owner==i) & active & rts & dcts.
- xbar_sel  out  NUM_PORTS  one-hot owner when active, all-zero when idle.
- rts  out  1  registered request-to-send to downstream.
- busy  out  1  registered, equals active.

Behaviour:
- State registers:
  - active (0=IDLE, 1=GRANT);
  - owner (index);
  - last (index);
  - hold_cnt (CNT_W bits);
  - rts.
- Reset values: active=0, owner=0, last=NUM_PORTS-1, hold_cnt=0, rts=0. Hence grant=0, xbar_sel=0, busy=0.
- Stall: when rts=1 and dcts=0, active/owner/last/hold_cnt hold and rts stays 1.
- Arbitration runs every non-stalled cycle, including cycles with rts=0.
- rts next value:
  - 0 if active=0;
  - 0 if rts&dcts (handshake done; one-cycle gap follows);
  - else 1.
  - Result: rts rises one cycle after entering GRANT; max throughput is one grant per 2 cycles.
- Handshake cycle: hs = rts&dcts. hold_cnt increments on hs. Arbitration uses eff = hold_cnt + hs.
- Keep rule: in GRANT, owner is kept when req[owner]=1 and (eff < MAX_HOLD or no other req bit set).
- Rotate rule (otherwise):
  - Scan ports owner+1, owner+2, ... cyclically, mod NUM_PORTS, excluding owner.
  - First requester becomes owner; hold_cnt=0; last=old owner.
  - If no other requester and req[owner]=0: go to IDLE; last=owner; hold_cnt=0.
- IDLE: scan from last+1 cyclically over all ports. First requester sets active=1, owner=it, hold_cnt=0. No requester: stay IDLE.
- After reset the first scan starts at port 0.
- Ownership change while rts=1 happens only on the hs cycle, so no grant is ever lost.
- Request withdrawn while rts=1 and dcts=0: stall still holds; grant completes when dcts arrives.
- hold_cnt saturates at MAX_HOLD; never wraps.
- rst mid-transfer: all state returns to reset values on the next edge regardless of dcts; rts drops the same edge.
- NUM_PORTS=1: rotation never occurs; MAX_HOLD ignored.

Decomposition:
- Package noc_arb_pkg:
  - port index constants (LOCAL=0, NORTH=1, EAST=2, WEST=3, SOUTH=4);
  - arb_state_e enum {ARB_IDLE, ARB_GRANT};
  - function onehot(idx, n).
- One sub-module, rr_pick: purely combinational.
  - Inputs: req vector, start index, exclude mask.
  - Outputs: found and index.
  - Instantiated once; the start index is muxed between owner+1 and last+1.

Test Plan:
- Reset then req=00001, dcts tied 1 → busy=1 at cycle 1, rts=1 at cycle 2, grant=00001 at cycle 2, then every 2 cycles; xbar_sel=00001 throughout.
- MAX_HOLD=4, req=00011 constant, dcts=1 → port 0 gets exactly 4 grants, then port 1 gets 4, alternating; never 5 consecutive.
- Owner 2 granted, rts=1, dcts held 0 for 6 cycles while req changes to 01000 → owner, rts and xbar_sel frozen; grant[2] fires the first cycle dcts=1; next owner is 3.
- From IDLE with last=3, req=11111 → owner=4 chosen; then req=00000 → IDLE, xbar_sel=0 and rts=0 within 1 cycle after the handshake.
- rst asserted during rts=1, dcts=0 → next edge: rts=0, grant=0, busy=0; after release with req=10001, port 0 wins.
- Single requester, MAX_HOLD=2, req=00100 for 10 grants → owner stays 2; hold_cnt saturates at 2; no idle gap beyond the standard one-cycle rts gap.

Source files
------------

// File: rtl/noc_arb_pkg.sv
// Shared definitions for the NoC output-stage round-robin arbiter.
package noc_arb_pkg;

   localparam int unsigned LOCAL     = 0;
   localparam int unsigned NORTH     = 1;
   localparam int unsigned EAST      = 2;
   localparam int unsigned WEST      = 3;
   localparam int unsigned SOUTH     = 4;
   localparam int unsigned MAX_PORTS = 16;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_e;

   // Bit idx set when idx is a valid port of an n-port router; callers truncate to n bits.
   function automatic logic [MAX_PORTS-1:0] onehot(input int unsigned idx, input int unsigned n);
      onehot = (idx < n) ? (MAX_PORTS'(1) << idx) : '0;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational cyclic search: first requesting port at or after start, skipping excluded ports.
module rr_pick #(
   parameter int NUM_PORTS = 5,
   parameter int IDX_W     = 3
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDX_W-1:0]     start,
   input  logic [NUM_PORTS-1:0] excl,
   output logic                 found,
   output logic [IDX_W-1:0]     idx
);

   logic [NUM_PORTS-1:0] cand;
   logic [NUM_PORTS-1:0] shifted;
   int                   p;

   assign cand = req & ~excl;

   always_comb begin
      found   = 1'b0;
      idx     = '0;
      p       = 0;
      shifted = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         p = int'(start) + k;
         if (p >= NUM_PORTS) p = p - NUM_PORTS;
         shifted = cand >> p;
         if (!found && shifted[0]) begin
            found = 1'b1;
            idx   = IDX_W'(p);
         end
      end
   end

endmodule

// File: rtl/noc_rr_arbiter.sv
// N-port round-robin output arbiter with hold limit and RTS/DCTS handshake to the next router.
//   state     | meaning
//   ARB_IDLE  | no owner; scan all ports starting after the last owner
//   ARB_GRANT | owner holds the crossbar; rts raised toward downstream
module noc_rr_arbiter
   import noc_arb_pkg::*;
#(
   parameter  int NUM_PORTS = 5,
   parameter  int MAX_HOLD  = 8,
   localparam int CNT_W     = $clog2(MAX_HOLD + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_PORTS-1:0] req,
   input  logic                 dcts,
   output logic [NUM_PORTS-1:0] grant,
   output logic [NUM_PORTS-1:0] xbar_sel,
   output logic                 rts,
   output logic                 busy
);

   localparam int               IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W:0]   EFF_MAX  = (CNT_W + 1)'(MAX_HOLD);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             rts_q, rts_d;

   logic                 active, hs, stall;
   logic [NUM_PORTS-1:0] owner_oh;
   logic                 req_own, req_others;
   logic [CNT_W:0]       eff;
   logic [CNT_W-1:0]     hold_inc;
   logic [IDX_W-1:0]     owner_inc, last_inc;
   logic [IDX_W-1:0]     pick_start;
   logic [NUM_PORTS-1:0] pick_excl;
   logic                 pick_found;
   logic [IDX_W-1:0]     pick_idx;

   assign active     = (state_q == ARB_GRANT);
   assign hs         = rts_q & dcts;
   assign stall      = rts_q & ~dcts;
   assign owner_oh   = NUM_PORTS'(onehot(32'(owner_q), NUM_PORTS));
   assign req_own    = |(req & owner_oh);
   assign req_others = |(req & ~owner_oh);
   assign eff        = {1'b0, hold_cnt_q} + (CNT_W + 1)'(hs);
   assign hold_inc   = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + CNT_W'(hs);
   assign owner_inc  = (int'(owner_q) == NUM_PORTS - 1) ? '0 : owner_q + IDX_W'(1);
   assign last_inc   = (int'(last_q) == NUM_PORTS - 1) ? '0 : last_q + IDX_W'(1);

   // One search engine: continue after the owner while granting, after the last owner when idle.
   assign pick_start = active ? owner_inc : last_inc;
   assign pick_excl  = active ? owner_oh : '0;

   rr_pick #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_W     (IDX_W)
   ) u_pick (
      .req   (req),
      .start (pick_start),
      .excl  (pick_excl),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      hold_cnt_d = hold_cnt_q;
      rts_d      = rts_q;
      if (stall) begin
         rts_d = 1'b1;
      end else if (!active) begin
         rts_d = 1'b0;
         if (pick_found) begin
            state_d    = ARB_GRANT;
            owner_d    = pick_idx;
            hold_cnt_d = '0;
         end
      end else begin
         if (req_own && ((eff < EFF_MAX) || !req_others)) begin
            hold_cnt_d = hold_inc;
         end else if (pick_found) begin
            owner_d    = pick_idx;
            last_d     = owner_q;
            hold_cnt_d = '0;
         end else begin
            state_d    = ARB_IDLE;
            last_d     = owner_q;
            hold_cnt_d = '0;
         end
         // Never leave rts up toward downstream on the edge we drop to idle.
         rts_d = ~hs & (state_d == ARB_GRANT);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB_IDLE;
         owner_q    <= IDX_W'(LOCAL);
         last_q     <= IDX_W'(NUM_PORTS - 1);
         hold_cnt_q <= '0;
         rts_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         hold_cnt_q <= hold_cnt_d;
         rts_q      <= rts_d;
      end
   end

   assign grant    = owner_oh & {NUM_PORTS{active & hs}};
   assign xbar_sel = active ? owner_oh : '0;
   assign rts      = rts_q;
   assign busy     = active;

endmodule
